// File: rtl/pe_stream_driver.sv
// pe_stream_driver: array-side driver for a single PE.
// Holds the filter taps and a stride-1 ifmap window, issues K multiply beats
// per output window together with the incoming psum, and collects the PE
// results into a credit-protected show-ahead FIFO.
`timescale 1ns/1ps
module pe_stream_driver #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int OUT_DEPTH   = 4,
   parameter int CNT_W       = 16
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               start,
   input  logic [$clog2(KERNEL_SIZE+1)-1:0]   kernel_size_cfg,
   input  logic [CNT_W-1:0]                   num_out_cfg,
   input  logic                               fltr_wr_en,
   input  logic [$clog2(KERNEL_SIZE)-1:0]     fltr_wr_addr,
   input  logic [DATA_WIDTH-1:0]              fltr_wr_data,
   input  logic                               ifmap_valid,
   output logic                               ifmap_ready,
   input  logic [DATA_WIDTH-1:0]              ifmap_data,
   input  logic                               psum_in_valid,
   output logic                               psum_in_ready,
   input  logic [2*DATA_WIDTH-1:0]            psum_in_data,
   output logic                               pe_en,
   output logic [DATA_WIDTH-1:0]              pe_ifmap,
   output logic [DATA_WIDTH-1:0]              pe_fltr,
   output logic [2*DATA_WIDTH-1:0]            pe_psum_m2p,
   output logic [$clog2(KERNEL_SIZE+1)-1:0]   pe_kernel_size,
   input  logic [2*DATA_WIDTH-1:0]            pe_psum_p2m,
   input  logic                               pe_valid,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [2*DATA_WIDTH-1:0]            out_data,
   output logic                               busy,
   output logic                               done,
   output logic                               err
);
   localparam int KW  = $clog2(KERNEL_SIZE+1);
   localparam int AW  = $clog2(KERNEL_SIZE);
   localparam int PW  = 2*DATA_WIDTH;
   localparam int FAW = $clog2(OUT_DEPTH);
   localparam int FCW = FAW + 1;
   localparam int SW  = FCW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [DATA_WIDTH-1:0] fltr [KERNEL_SIZE];
   logic [DATA_WIDTH-1:0] win  [KERNEL_SIZE];

   logic [KW-1:0]    k_q, k_m1, prime_cnt, beat, cur_beat;
   logic [CNT_W-1:0] n_q, win_cnt, win_cnt_nx;
   logic             active;
   logic [PW-1:0]    psum_q;
   logic [FCW-1:0]   outst, fcnt;
   logic [PW-1:0]    fifo_mem [OUT_DEPTH];
   logic [FAW-1:0]   wptr, rptr;

   logic idle_start, cfg_ok, credit_ok, start_win, issuing, last_beat;
   logic run_exit, prime_last, capture, fifo_empty, fifo_full, push, pop, drop;

   // Job control and window-issue decode
   always_comb begin
      idle_start = (state == S_IDLE) && start;
      cfg_ok     = (kernel_size_cfg != '0) && (kernel_size_cfg <= KW'(KERNEL_SIZE))
                   && (num_out_cfg != '0);
      k_m1       = k_q - KW'(1);
      // Credit counts results already queued plus results still inside the PE,
      // so a window only starts when its result is guaranteed a FIFO slot.
      credit_ok  = ({1'b0, fcnt} + {1'b0, outst}) < SW'(OUT_DEPTH);
      start_win  = (state == S_RUN) && !active && (win_cnt < n_q)
                   && ifmap_valid && psum_in_valid && credit_ok;
      issuing    = (state == S_RUN) && (active || start_win);
      cur_beat   = active ? beat : '0;
      last_beat  = issuing && (cur_beat == k_m1);
      win_cnt_nx = (start_win && (win_cnt != '1)) ? win_cnt + CNT_W'(1) : win_cnt;
      run_exit   = last_beat && (win_cnt_nx >= n_q);
      prime_last = (state == S_PRIME) && ifmap_valid && (prime_cnt == k_q - KW'(2));
   end

   // Result capture and FIFO push/pop decode
   always_comb begin
      fifo_empty = (fcnt == '0);
      fifo_full  = (fcnt == FCW'(OUT_DEPTH));
      pop        = !fifo_empty && out_ready;
      capture    = (state != S_IDLE) && pe_valid && (outst != '0);
      // A pop in the same cycle frees the slot, so push at full is legal then.
      push       = capture && (!fifo_full || pop);
      drop       = capture && fifo_full && !pop;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) begin
                     if (!cfg_ok)                        state_nx = S_FIN;
                     else if (kernel_size_cfg == KW'(1)) state_nx = S_RUN;
                     else                                state_nx = S_PRIME;
                  end
         S_PRIME: if (prime_last) state_nx = S_RUN;
         S_RUN:   if (run_exit) state_nx = S_DRAIN;
         S_DRAIN: if ((outst == '0) && fifo_empty) state_nx = S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: handshakes, enables and status
   always_comb begin
      ifmap_ready   = (state == S_PRIME) || start_win;
      psum_in_ready = start_win;
      pe_en         = issuing;
      busy          = (state != S_IDLE);
      done          = (state == S_FIN);
   end

   // PE operand selection; with K==1 the only sample arrives on the start cycle
   always_comb begin
      pe_ifmap = '0;
      pe_fltr  = '0;
      if (issuing) begin
         pe_ifmap = (start_win && (k_q == KW'(1))) ? ifmap_data : win[cur_beat[AW-1:0]];
         pe_fltr  = fltr[cur_beat[AW-1:0]];
      end
      // The register is only loaded at the end of beat 0, so bypass it then.
      pe_psum_m2p = start_win ? psum_in_data : psum_q;
   end

   assign pe_kernel_size = k_q;
   assign out_valid      = !fifo_empty;
   assign out_data       = fifo_mem[rptr];

   // Filter regfile; writable only while idle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < KERNEL_SIZE; i++) fltr[i] <= '0;
      end else if ((state == S_IDLE) && fltr_wr_en && (int'(fltr_wr_addr) < KERNEL_SIZE)) begin
         fltr[fltr_wr_addr] <= fltr_wr_data;
      end
   end

   // Job configuration latched on an accepted start
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         k_q <= '0;
         n_q <= '0;
      end else if (idle_start && cfg_ok) begin
         k_q <= kernel_size_cfg;
         n_q <= num_out_cfg;
      end
   end

   // Sticky error on a dropped result; a start clears it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)           err <= 1'b0;
      else if (idle_start) err <= 1'b0;
      else if (drop)       err <= 1'b1;
   end

   // Ifmap window: primed from index 0, newest sample lands in slot K-1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < KERNEL_SIZE; i++) win[i] <= '0;
      end else if ((state == S_PRIME) && ifmap_valid) begin
         win[prime_cnt[AW-1:0]] <= ifmap_data;
      end else if (state == S_RUN) begin
         if (last_beat)
            for (int i = 0; i < KERNEL_SIZE-1; i++) win[i] <= win[i+1];
         // Later assignment wins: for K==1 the fresh sample is kept.
         if (start_win) win[k_m1[AW-1:0]] <= ifmap_data;
      end
   end

   // Prime, window and beat counters plus the held psum
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prime_cnt <= '0;
         win_cnt   <= '0;
         beat      <= '0;
         active    <= 1'b0;
         psum_q    <= '0;
      end else if (idle_start) begin
         prime_cnt <= '0;
         win_cnt   <= '0;
         beat      <= '0;
         active    <= 1'b0;
      end else begin
         if ((state == S_PRIME) && ifmap_valid && (prime_cnt != '1))
            prime_cnt <= prime_cnt + KW'(1);
         win_cnt <= win_cnt_nx;
         if (start_win) psum_q <= psum_in_data;
         if (last_beat) begin
            active <= 1'b0;
            beat   <= '0;
         end else if (issuing) begin
            active <= 1'b1;
            beat   <= cur_beat + KW'(1);
         end
      end
   end

   // Results in flight inside the PE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) outst <= '0;
      else if (start_win && !capture && (outst != '1)) outst <= outst + FCW'(1);
      else if (capture && !start_win)                  outst <= outst - FCW'(1);
   end

   // Output FIFO storage and pointers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
         wptr <= '0;
         rptr <= '0;
         fcnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr] <= pe_psum_p2m;
            wptr           <= wptr + FAW'(1);
         end
         if (pop) rptr <= rptr + FAW'(1);
         if (push && !pop)      fcnt <= fcnt + FCW'(1);
         else if (pop && !push) fcnt <= fcnt - FCW'(1);
      end
   end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver: behavioural PE, expected-result queue filled
// from the stimulus, results popped and compared as the stream delivers them.
`timescale 1ns/1ps
module tb_pe_stream_driver;
   localparam int DW = 16, KS = 3, OD = 4, CW = 16;
   localparam int KW = $clog2(KS+1), AW = $clog2(KS), PW = 2*DW;

   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;

   logic          start;
   logic [KW-1:0] kernel_size_cfg;
   logic [CW-1:0] num_out_cfg;
   logic          fltr_wr_en;
   logic [AW-1:0] fltr_wr_addr;
   logic [DW-1:0] fltr_wr_data;
   logic          ifmap_valid, ifmap_ready;
   logic [DW-1:0] ifmap_data;
   logic          psum_in_valid, psum_in_ready;
   logic [PW-1:0] psum_in_data;
   logic          pe_en;
   logic [DW-1:0] pe_ifmap, pe_fltr;
   logic [PW-1:0] pe_psum_m2p, pe_psum_p2m;
   logic [KW-1:0] pe_kernel_size;
   logic          pe_valid;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_data;
   logic          busy, done, err;

   int checks = 0, errors = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] exp_e;
   logic [DW-1:0] xs[$];
   logic [PW-1:0] ps[$];
   logic [DW-1:0] taps[KS];
   int pe_cyc = 0, done_cnt = 0, gap_err = 0, tb_beat = 0, tb_k = 1;

   pe_stream_driver #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .OUT_DEPTH(OD), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .kernel_size_cfg(kernel_size_cfg), .num_out_cfg(num_out_cfg),
      .fltr_wr_en(fltr_wr_en), .fltr_wr_addr(fltr_wr_addr), .fltr_wr_data(fltr_wr_data),
      .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
      .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
      .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_psum_m2p(pe_psum_m2p),
      .pe_kernel_size(pe_kernel_size), .pe_psum_p2m(pe_psum_p2m), .pe_valid(pe_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .err(err)
   );

   // Behavioural PE: first beat adds the incoming psum, result one cycle after the last beat
   logic [PW-1:0] pe_acc, pe_mac;
   logic [KW-1:0] pe_cnt;
   assign pe_mac = ((pe_cnt == '0) ? pe_psum_m2p : pe_acc) + (PW'(pe_ifmap) * PW'(pe_fltr));
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pe_valid <= 1'b0; pe_psum_p2m <= '0; pe_acc <= '0; pe_cnt <= '0;
      end else begin
         pe_valid <= 1'b0;
         if (pe_en) begin
            if (pe_cnt == pe_kernel_size - KW'(1)) begin
               pe_valid <= 1'b1; pe_psum_p2m <= pe_mac; pe_cnt <= '0;
            end else begin
               pe_acc <= pe_mac; pe_cnt <= pe_cnt + KW'(1);
            end
         end
      end
   end

   // Monitor: beat tracking, done count and in-order result comparison
   initial forever begin
      @(negedge clk);
      if (!rstn) tb_beat = 0;
      else begin
         if (pe_en) begin
            pe_cyc++;
            tb_beat = (tb_beat + 1 >= tb_k) ? 0 : tb_beat + 1;
         end else if (tb_beat != 0) gap_err++;
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_data: got %0d, no result expected", out_data);
            end else begin
               exp_e = exp_q.pop_front();
               if (out_data !== exp_e) begin
                  errors++;
                  $display("FAIL out_data: got %0d, expected %0d", out_data, exp_e);
               end
            end
         end
      end
   end

   task automatic write_tap(input int addr, input int val);
      fltr_wr_en = 1'b1; fltr_wr_addr = AW'(addr); fltr_wr_data = DW'(val);
      @(posedge clk); #1;
      fltr_wr_en = 1'b0;
      taps[addr] = DW'(val);
   endtask

   task automatic drive_ifmap(input bit bubble);
      int i = 0; bit fire;
      for (int cyc = 0; cyc < 500 && i < xs.size(); cyc++) begin
         ifmap_valid = !bubble || (cyc % 2 == 0);
         ifmap_data  = xs[i];
         @(negedge clk); fire = ifmap_valid && ifmap_ready;
         @(posedge clk); #1;
         if (fire) i++;
      end
      ifmap_valid = 1'b0;
   endtask

   task automatic drive_psum();
      int i = 0; bit fire;
      for (int cyc = 0; cyc < 500 && i < ps.size(); cyc++) begin
         psum_in_valid = 1'b1;
         psum_in_data  = ps[i];
         @(negedge clk); fire = psum_in_valid && psum_in_ready;
         @(posedge clk); #1;
         if (fire) i++;
      end
      psum_in_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 600 && !ok; c++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
   endtask

   task automatic run_job(input int k, input int n, input bit bubble, output bit ok);
      logic [PW-1:0] e;
      for (int w = 0; w < n; w++) begin
         e = ps[w];
         for (int b = 0; b < k; b++) e += PW'(taps[b]) * PW'(xs[w+b]);
         exp_q.push_back(e);
      end
      tb_k = k; pe_cyc = 0; done_cnt = 0; gap_err = 0;
      kernel_size_cfg = KW'(k); num_out_cfg = CW'(n);
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      fork
         drive_ifmap(bubble);
         drive_psum();
         wait_done(ok);
      join
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL reset_out: got valid=%0b data=%0d, expected 0/0", out_valid, out_data); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_status: got busy=%0b done=%0b err=%0b, expected 0", busy, done, err); end
      checks++; if (pe_en !== 1'b0 || ifmap_ready !== 1'b0 || psum_in_ready !== 1'b0) begin errors++; $display("FAIL reset_hs: got pe_en=%0b ifr=%0b psr=%0b, expected 0", pe_en, ifmap_ready, psum_in_ready); end
      checks++; if (pe_psum_m2p !== '0 || pe_kernel_size !== '0) begin errors++; $display("FAIL reset_pe: got psum=%0d k=%0d, expected 0", pe_psum_m2p, pe_kernel_size); end
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok;
      write_tap(0, 1); write_tap(1, 2); write_tap(2, 3);
      xs = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      ps = {32'd0, 32'd0, 32'd0};
      fork
         run_job(3, 3, 1'b0, ok);
         begin
            // Write attempted while busy; the model taps stay {1,2,3}
            repeat (4) @(posedge clk); #1;
            fltr_wr_en = 1'b1; fltr_wr_addr = '0; fltr_wr_data = 16'd99;
            @(posedge clk); #1 fltr_wr_en = 1'b0;
         end
      join
      checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no done, expected done"); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d, expected 1", done_cnt); end
      checks++; if (pe_cyc != 9) begin errors++; $display("FAIL basic_pe_en: got %0d cycles, expected 9", pe_cyc); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_chain();
      bit ok;
      xs = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      ps = {32'd100, 32'd200, 32'd300};
      run_job(3, 3, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL chain_done: got no done, expected done"); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL chain_left: got %0d missing, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_backpressure();
      bit ok;
      xs.delete(); ps.delete();
      for (int i = 0; i < 10; i++) xs.push_back(DW'(3*i + 1));
      for (int i = 0; i < 8; i++) ps.push_back(PW'(1000*i));
      fork
         run_job(3, 8, 1'b0, ok);
         begin
            out_ready = 1'b0;
            repeat (60) @(posedge clk); #1;
            checks++; if (pe_cyc != 12) begin errors++; $display("FAIL bp_windows: got %0d beats, expected 12", pe_cyc); end
            checks++; if (err !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_status: got err=%0b valid=%0b, expected 0/1", err, out_valid); end
            out_ready = 1'b1;
         end
      join
      checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL bp_done: got done=%0b err=%0b, expected 1/0", ok, err); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d missing, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_bubbles();
      bit ok;
      write_tap(0, 3); write_tap(1, 1); write_tap(2, 4);
      xs.delete(); ps.delete();
      for (int i = 0; i < 7; i++) xs.push_back(DW'($urandom_range(0, 255)));
      for (int i = 0; i < 5; i++) ps.push_back(PW'($urandom_range(0, 65535)));
      run_job(3, 5, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bub_done: got no done, expected done"); end
      checks++; if (gap_err != 0) begin errors++; $display("FAIL bub_gap: got %0d mid-window gaps, expected 0", gap_err); end
      checks++; if (pe_cyc != 15) begin errors++; $display("FAIL bub_pe_en: got %0d, expected 15", pe_cyc); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bub_left: got %0d missing, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_k1();
      bit ok;
      write_tap(0, 5);
      exp_q.push_back(32'd35);
      tb_k = 1; pe_cyc = 0; done_cnt = 0;
      ifmap_valid = 1'b1; ifmap_data = 16'd7; psum_in_valid = 1'b1; psum_in_data = '0;
      kernel_size_cfg = KW'(1); num_out_cfg = CW'(1);
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++; if (pe_en !== 1'b1 || ifmap_ready !== 1'b1) begin errors++; $display("FAIL k1_noprime: got pe_en=%0b ifr=%0b, expected 1/1", pe_en, ifmap_ready); end
      @(posedge clk); #1 ifmap_valid = 1'b0; psum_in_valid = 1'b0;
      wait_done(ok);
      @(posedge clk); #1;
      checks++; if (!ok || done_cnt != 1 || pe_cyc != 1) begin errors++; $display("FAIL k1_job: got done=%0b cnt=%0d beats=%0d, expected 1/1/1", ok, done_cnt, pe_cyc); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL k1_left: got %0d missing, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_n0();
      ifmap_valid = 1'b1; psum_in_valid = 1'b1;
      kernel_size_cfg = KW'(3); num_out_cfg = '0;
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL n0_done: got %0b, expected 1", done); end
      checks++; if (ifmap_ready !== 1'b0 || psum_in_ready !== 1'b0 || pe_en !== 1'b0) begin errors++; $display("FAIL n0_hs: got ifr=%0b psr=%0b pe_en=%0b, expected 0", ifmap_ready, psum_in_ready, pe_en); end
      @(posedge clk); #1 ifmap_valid = 1'b0; psum_in_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n0_idle: got busy=%0b, expected 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0, ok;
      tb_k = 3; done_cnt = 0;
      ifmap_valid = 1'b1; ifmap_data = 16'd1; psum_in_valid = 1'b1; psum_in_data = '0;
      kernel_size_cfg = KW'(3); num_out_cfg = CW'(3);
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); if (pe_en) seen = 1'b1; end
      checks++; if (!seen) begin errors++; $display("FAIL rst_mid_run: got no beat, expected beat 0"); end
      @(negedge clk); rstn = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || pe_en !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got valid=%0b busy=%0b pe_en=%0b, expected 0", out_valid, busy, pe_en); end
      ifmap_valid = 1'b0; psum_in_valid = 1'b0;
      repeat (3) @(posedge clk); #1 rstn = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses, expected 0", done_cnt); end
      // Taps were cleared by reset; reload and run a fresh job
      write_tap(0, 1); write_tap(1, 2); write_tap(2, 3);
      xs = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      ps = {32'd0, 32'd0, 32'd0};
      run_job(3, 3, 1'b0, ok);
      checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_fresh: got done=%0b missing=%0d, expected 1/0", ok, exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      start = 1'b0; kernel_size_cfg = '0; num_out_cfg = '0;
      fltr_wr_en = 1'b0; fltr_wr_addr = '0; fltr_wr_data = '0;
      ifmap_valid = 1'b0; ifmap_data = '0; psum_in_valid = 1'b0; psum_in_data = '0;
      out_ready = 1'b1;
      for (int i = 0; i < KS; i++) taps[i] = '0;
      test_reset();
      test_basic();
      test_chain();
      test_backpressure();
      test_bubbles();
      test_k1();
      test_n0();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
